forwarding_divide_unit: RTL and testbench

Multi-cycle 32-bit integer divide execute unit and producer side of the forwarding interface. It publishes a stage_register_data_t record (registerId, dataReady, data) that downstream forwarding logic consumes to forward data or stall. While busy it advertises its destination register with dataReady=0, which forces dependent instructions to stall. On completion it publishes the result for one cycle alongside the writeback pulse.

---
 rtl/forwarding_divide_unit_pkg.sv | 26 ++
 rtl/forwarding_divide_unit_divide_step.sv | 29 ++
 rtl/forwarding_divide_unit.sv | 153 +++++++++++++++
 tb/tb_forwarding_divide_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/forwarding_divide_unit_pkg.sv
// Shared types for the divide execute unit and its forwarding record.
// Consumed by the top-level unit, the restoring-step datapath and the forwarding consumers.
package forwarding_divide_unit_pkg;

    typedef logic [31:0] int_t;
    typedef logic [4:0]  register_id_t;

    localparam register_id_t ZERO = 5'd0;

    typedef struct packed {
        register_id_t registerId;
        logic         dataReady;
        int_t         data;
    } stage_register_data_t;

    // Idle producer: architectural zero register, always ready, so nothing stalls on it.
    localparam stage_register_data_t NO_SUCH_STAGE = '{registerId: ZERO, dataReady: 1'b1, data: 32'd0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/forwarding_divide_unit_divide_step.sv
// One combinational restoring-division iteration on magnitudes.
// quoIn holds the not-yet-consumed dividend bits in its MSBs; quotient bits enter at the LSB.
module divide_step
    import forwarding_divide_unit_pkg::*;
(
    input  int_t remIn,
    input  int_t quoIn,
    input  int_t divisor,
    output int_t remOut,
    output int_t quoOut
);

    logic [32:0] shifted;
    logic [32:0] trial;

    // remIn < divisor always holds, so a non-negative trial always fits back in 32 bits.
    assign shifted = {remIn, quoIn[31]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        remOut = shifted[31:0];
        quoOut = {quoIn[30:0], 1'b0};
        if (!trial[32]) begin
            remOut = trial[31:0];
            quoOut = {quoIn[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/forwarding_divide_unit.sv
// Multi-cycle 32-bit divide unit that publishes its destination register to forwarding logic.
// Optional FORWARDING_DIVIDE_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module forwarding_divide_unit
    import forwarding_divide_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 isSigned,
    input  logic                 wantRemainder,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  register_id_t         destRegister,
    input  logic                 flush,
    output logic                 busy,
    output logic                 resultValid,
    output int_t                 result,
    output stage_register_data_t forwardInfo
);

    localparam int CNT_W = $clog2(ITERATIONS);

    div_state_t         state;
    logic [CNT_W-1:0]   counter;
    int_t               remReg;
    int_t               quoReg;
    int_t               divReg;
    logic               negQuo;
    logic               negRem;
    logic               wantRem;
    register_id_t       destReg;

    int_t               remNext;
    int_t               quoNext;
    logic [WIDTH-1:0]   absDividend;
    logic [WIDTH-1:0]   absDivisor;
    logic signed [WIDTH-1:0] dividendS;
    logic signed [WIDTH-1:0] divisorS;
    logic               dividendNeg;
    logic               divisorNeg;
    logic               earlyOut;
    logic               lastStep;
    logic               issue;
    int_t               zeroResult;
    int_t               fixupResult;

    function automatic int_t condNegate(input int_t value, input logic negate);
        return negate ? int_t'(-value) : value;
    endfunction

    divide_step uStep (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divReg),
        .remOut  (remNext),
        .quoOut  (quoNext)
    );

    assign dividendS   = dividend;
    assign divisorS    = divisor;
    assign dividendNeg = isSigned && (dividendS < 0);
    assign divisorNeg  = isSigned && (divisorS < 0);
    assign absDividend = condNegate(dividend, dividendNeg);
    assign absDivisor  = condNegate(divisor, divisorNeg);
    assign issue       = (state == IDLE) && start;
    assign lastStep    = (counter == CNT_W'(ITERATIONS - 1));
    assign zeroResult  = wantRemainder ? dividend : '1;
    assign fixupResult = wantRem ? condNegate(remReg, negRem) : condNegate(quoReg, negQuo);

`ifdef FORWARDING_DIVIDE_EARLY_OUT_EN
    assign earlyOut = (absDividend < absDivisor);
`else
    assign earlyOut = 1'b0;
`endif

    // Control and published outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            result      <= '0;
            forwardInfo <= NO_SUCH_STAGE;
        end else begin
            resultValid <= 1'b0;
            if (flush) begin
                state       <= IDLE;
                busy        <= 1'b0;
                forwardInfo <= NO_SUCH_STAGE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            counter <= '0;
                            busy    <= 1'b1;
                            if (divisor == '0) begin
                                state       <= DONE;
                                resultValid <= 1'b1;
                                result      <= zeroResult;
                                forwardInfo <= '{registerId: destRegister, dataReady: 1'b1, data: zeroResult};
                            end else begin
                                state       <= earlyOut ? FIXUP : BUSY;
                                forwardInfo <= '{registerId: destRegister, dataReady: 1'b0, data: 32'd0};
                            end
                        end
                    end
                    BUSY: begin
                        counter <= counter + 1'b1;
                        if (lastStep) begin
                            state <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        state       <= DONE;
                        resultValid <= 1'b1;
                        result      <= fixupResult;
                        forwardInfo <= '{registerId: destReg, dataReady: 1'b1, data: fixupResult};
                    end
                    DONE: begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        forwardInfo <= NO_SUCH_STAGE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Datapath registers: loaded on issue, stepped while iterating
    always_ff @(posedge clock) begin
        if (issue) begin
            remReg  <= earlyOut ? absDividend : '0;
            quoReg  <= earlyOut ? '0 : absDividend;
            divReg  <= absDivisor;
            negQuo  <= dividendNeg ^ divisorNeg;
            negRem  <= dividendNeg;
            wantRem <= wantRemainder;
            destReg <= destRegister;
        end else if (state == BUSY) begin
            remReg <= remNext;
            quoReg <= quoNext;
        end
    end

endmodule

// File: tb/tb_forwarding_divide_unit.sv
// Self-checking bench for forwarding_divide_unit: vector table with a result scoreboard,
// plus flush, ignored-restart and mid-operation reset sequences.
module tb_forwarding_divide_unit;
    import forwarding_divide_unit_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 isSigned = 1'b0;
    logic                 wantRemainder = 1'b0;
    logic [31:0]          dividend = '0;
    logic [31:0]          divisor = '0;
    register_id_t         destRegister = '0;
    logic                 flush = 1'b0;
    logic                 busy;
    logic                 resultValid;
    int_t                 result;
    stage_register_data_t forwardInfo;

    int checks = 0;
    int failures = 0;
    int_t sbQueue[$];

    typedef struct {
        string        name;
        logic         sgn;
        logic         rem;
        int_t         a;
        int_t         b;
        register_id_t dest;
        int_t         expected;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    forwarding_divide_unit dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .isSigned      (isSigned),
        .wantRemainder (wantRemainder),
        .dividend      (dividend),
        .divisor       (divisor),
        .destRegister  (destRegister),
        .flush         (flush),
        .busy          (busy),
        .resultValid   (resultValid),
        .result        (result),
        .forwardInfo   (forwardInfo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int_t mag(input int_t v, input logic sgn);
        return (sgn && v[31]) ? int_t'(-v) : v;
    endfunction

    function automatic int expLatency(input vec_t v);
        if (v.b == 0) return 1;
`ifdef FORWARDING_DIVIDE_EARLY_OUT_EN
        if (mag(v.a, v.sgn) < mag(v.b, v.sgn)) return 2;
`endif
        return 34;
    endfunction

    task automatic issueOp(input logic sgn, input logic rem, input int_t a, input int_t b,
                           input register_id_t dest);
        isSigned      = sgn;
        wantRemainder = rem;
        dividend      = a;
        divisor       = b;
        destRegister  = dest;
        start         = 1'b1;
    endtask

    task automatic checkIdle(input string name);
        check({name, " busy"}, 64'(busy), 64'(1'b0));
        check({name, " valid"}, 64'(resultValid), 64'(1'b0));
        check({name, " fwd"}, 64'(forwardInfo), 64'(NO_SUCH_STAGE));
    endtask

    task automatic runVector(input vec_t v);
        int   lat;
        int   expLat;
        bit   seen;
        int_t e;
        lat    = 0;
        seen   = 0;
        expLat = expLatency(v);
        @(negedge clock);
        issueOp(v.sgn, v.rem, v.a, v.b, v.dest);
        sbQueue.push_back(v.expected);
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc == 1 && expLat > 1)
                check({v.name, " fwd pending"}, 64'(forwardInfo), 64'({v.dest, 1'b0, 32'h0}));
            if (resultValid) begin
                seen = 1;
                lat  = cyc;
                if (sbQueue.size() == 0) begin
                    check({v.name, " unexpected result"}, 64'(1), 64'(0));
                end else begin
                    e = sbQueue.pop_front();
                    check({v.name, " result"}, 64'(result), 64'(e));
                    check({v.name, " fwd ready"}, 64'(forwardInfo), 64'({v.dest, 1'b1, e}));
                end
            end
        end
        if (!seen) begin
            check({v.name, " timeout"}, 64'(0), 64'(1));
            sbQueue.delete();
        end
        check({v.name, " latency"}, 64'(lat), 64'(expLat));
        @(negedge clock);
        checkIdle({v.name, " after"});
    endtask

    task automatic countValids(input int cycles, output int count, output int_t lastVal);
        count   = 0;
        lastVal = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (resultValid) begin
                count++;
                lastVal = result;
            end
        end
    endtask

    initial begin
        int   n;
        int_t val;

        vecs.push_back('{"u100/7q",   1'b0, 1'b0, 32'd100,        32'd7,          5'd8,  32'd14});
        vecs.push_back('{"u100/7r",   1'b0, 1'b1, 32'd100,        32'd7,          5'd8,  32'd2});
        vecs.push_back('{"s-7/2r",    1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          5'd9,  32'hFFFFFFFF});
        vecs.push_back('{"s-7/2q",    1'b1, 1'b0, 32'hFFFFFFF9,   32'd2,          5'd9,  32'hFFFFFFFD});
        vecs.push_back('{"u5/0q",     1'b0, 1'b0, 32'd5,          32'd0,          5'd4,  32'hFFFFFFFF});
        vecs.push_back('{"u5/0r",     1'b0, 1'b1, 32'd5,          32'd0,          5'd4,  32'd5});
        vecs.push_back('{"s-5/0r",    1'b1, 1'b1, 32'hFFFFFFFB,   32'd0,          5'd5,  32'hFFFFFFFB});
        vecs.push_back('{"sovfq",     1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'h80000000});
        vecs.push_back('{"sovfr",     1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'd0});
        vecs.push_back('{"s7/-2q",    1'b1, 1'b0, 32'd7,          32'hFFFFFFFE,   5'd11, 32'hFFFFFFFD});
        vecs.push_back('{"s7/-2r",    1'b1, 1'b1, 32'd7,          32'hFFFFFFFE,   5'd11, 32'd1});
        vecs.push_back('{"umax/1q",   1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          5'd31, 32'hFFFFFFFF});
        vecs.push_back('{"u3/9q",     1'b0, 1'b0, 32'd3,          32'd9,          5'd12, 32'd0});
        vecs.push_back('{"u3/9r",     1'b0, 1'b1, 32'd3,          32'd9,          5'd12, 32'd3});
        vecs.push_back('{"s-3/9r",    1'b1, 1'b1, 32'hFFFFFFFD,   32'd9,          5'd13, 32'hFFFFFFFD});
        vecs.push_back('{"u20/3zero", 1'b0, 1'b0, 32'd20,         32'd3,          ZERO,  32'd6});

        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkIdle("reset");
        check("reset result", 64'(result), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        checkIdle("post reset");

        foreach (vecs[i]) runVector(vecs[i]);

        // Flush mid-operation: no writeback afterwards.
        @(negedge clock);
        issueOp(1'b0, 1'b0, 32'd100, 32'd7, 5'd8);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc == 10) flush = 1'b1;
        end
        @(negedge clock);
        flush = 1'b0;
        checkIdle("flush c11");
        countValids(40, n, val);
        check("flush no writeback", 64'(n), 64'(0));

        // Flush and start together: start is dropped.
        @(negedge clock);
        issueOp(1'b0, 1'b0, 32'd50, 32'd5, 5'd2);
        flush = 1'b1;
        @(negedge clock);
        start = 1'b0;
        flush = 1'b0;
        checkIdle("flush+start");

        // Start re-asserted while busy is ignored.
        @(negedge clock);
        issueOp(1'b0, 1'b0, 32'd100, 32'd7, 5'd3);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc >= 5 && cyc <= 7) issueOp(1'b0, 1'b0, 32'd50, 32'd5, 5'd6);
        end
        start = 1'b0;
        countValids(60, n, val);
        check("restart count", 64'(n), 64'(1));
        check("restart value", 64'(val), 64'(14));

        // Reset asserted mid-operation takes effect immediately.
        @(negedge clock);
        issueOp(1'b0, 1'b0, 32'd100, 32'd7, 5'd8);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clock);
            start = 1'b0;
        end
        check("pre-reset busy", 64'(busy), 64'(1'b1));
        #1 reset = 1'b0;
        #1;
        checkIdle("async reset");
        check("async reset result", 64'(result), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        countValids(40, n, val);
        check("reset no writeback", 64'(n), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
